// File: rtl/sync_fifo_flags.sv
// rtl/sync_fifo_flags.sv - single-clock FIFO with occupancy count, threshold flags and error pulses
//
// Purpose:
//   Parametrised single-clock FIFO. Keeps an explicit occupancy count and
//   derives full/empty/almost_full/almost_empty from it. A rejected write or
//   read produces a registered one-cycle overflow/underflow pulse and changes
//   no other state.
//
// Optional feature macro: SYNC_FIFO_FWFT_EN
//   Defined   : first-word-fall-through. data_out shows the head word
//               combinationally while not empty (0 when empty), and read_en
//               pops the head.
//   Undefined : registered read. data_out updates the cycle after an
//               accepted read and holds otherwise.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   write_en     in   write request
//   data_in      in   write data, DATA_WIDTH bits
//   read_en      in   read request (pop acknowledge in FWFT mode)
//   data_out     out  read data, DATA_WIDTH bits
//   full         out  count == DEPTH
//   empty        out  count == 0
//   almost_full  out  count >= AF_THRESH
//   almost_empty out  count <= AE_THRESH
//   count        out  occupancy 0..DEPTH, $clog2(DEPTH)+1 bits
//   overflow     out  one-cycle pulse: write rejected
//   underflow    out  one-cycle pulse: read rejected

module sync_fifo_flags #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     write_en,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic                     read_en,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("sync_fifo_flags: DEPTH must be a power of two and at least 4");
  end
  if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_bad_af
    $error("sync_fifo_flags: AF_THRESH must be in 1..DEPTH");
  end
  if ((AE_THRESH < 0) || (AE_THRESH > DEPTH - 1)) begin : g_bad_ae
    $error("sync_fifo_flags: AE_THRESH must be in 0..DEPTH-1");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          overflow_q,  overflow_d;
  logic          underflow_q, underflow_d;

  logic wr_ok;
  logic rd_ok;

  // Flags come straight from the count register so they never glitch.
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // A full FIFO still takes a write when the same cycle pops a word.
  assign rd_ok = read_en && !empty;
  assign wr_ok = write_en && (!full || rd_ok);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = write_en && !wr_ok;
    underflow_d = read_en && !rd_ok;

    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (rd_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately not reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (!reset && wr_ok) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign data_out = empty ? '0 : mem_q[rd_ptr_q];
`else
  logic [DATA_WIDTH-1:0] data_out_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_q <= '0;
    end else if (rd_ok) begin
      data_out_q <= mem_q[rd_ptr_q];
    end
  end

  assign data_out = data_out_q;
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb/tb_sync_fifo_flags.sv - directed self-checking bench for sync_fifo_flags

module tb_sync_fifo_flags;

  logic       clk;
  logic       reset;
  logic       write_en;
  logic [7:0] data_in;
  logic       read_en;
  logic [7:0] data_out;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  int total = 0;
  int bad   = 0;

  sync_fifo_flags #(
    .DATA_WIDTH (8),
    .DEPTH      (16),
    .AF_THRESH  (14),
    .AE_THRESH  (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .write_en     (write_en),
    .data_in      (data_in),
    .read_en      (read_en),
    .data_out     (data_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    write_en = 1'b0;
    read_en  = 1'b0;
    data_in  = 8'h00;
    tick();
    reset = 1'b0;

    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ae", almost_empty, 1);
    chk("rst_af", almost_full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);
    chk("rst_dout", data_out, 0);

`ifndef SYNC_FIFO_FWFT_EN
    // 1: single write, idle, single read
    write_en = 1'b1; data_in = 8'hAA;
    tick();
    write_en = 1'b0;
    chk("t1_count1", count, 1);
    chk("t1_empty0", empty, 0);
    tick();
    chk("t1_count_idle", count, 1);
    read_en = 1'b1;
    tick();
    read_en = 1'b0;
    chk("t1_count0", count, 0);
    chk("t1_dout", data_out, 8'hAA);
    chk("t1_empty1", empty, 1);
    chk("t1_unf", underflow, 0);
    chk("t1_ovf", overflow, 0);

    // 2: fill to full, flag thresholds, overflow, drain in order
    for (int i = 0; i < 16; i++) begin
      write_en = 1'b1; data_in = 8'(i);
      tick();
      chk("t2_fill_count", count, i + 1);
      chk("t2_fill_ae", almost_empty, ((i + 1) <= 2) ? 1 : 0);
      chk("t2_fill_af", almost_full, ((i + 1) >= 14) ? 1 : 0);
      chk("t2_fill_full", full, ((i + 1) == 16) ? 1 : 0);
    end
    data_in = 8'hFF;
    tick();
    write_en = 1'b0;
    chk("t2_ovf_pulse", overflow, 1);
    chk("t2_ovf_count", count, 16);
    tick();
    chk("t2_ovf_clear", overflow, 0);
    for (int i = 0; i < 16; i++) begin
      read_en = 1'b1;
      tick();
      chk("t2_drain_dout", data_out, i);
      chk("t2_drain_count", count, 15 - i);
    end
    read_en = 1'b0;
    chk("t2_empty", empty, 1);

    // 3: simultaneous write+read while full, then wrap check
    for (int i = 0; i < 16; i++) begin
      write_en = 1'b1; data_in = 8'(i);
      tick();
    end
    chk("t3_full", full, 1);
    write_en = 1'b1; data_in = 8'h55; read_en = 1'b1;
    tick();
    write_en = 1'b0;
    chk("t3_count", count, 16);
    chk("t3_ovf", overflow, 0);
    chk("t3_dout", data_out, 8'h00);
    for (int i = 1; i < 16; i++) begin
      tick();
      chk("t3_drain_dout", data_out, i);
    end
    tick();
    read_en = 1'b0;
    chk("t3_last_dout", data_out, 8'h55);
    chk("t3_empty", empty, 1);

    // 4: underflow alone, then read+write on empty
    read_en = 1'b1;
    tick();
    read_en = 1'b0;
    chk("t4_unf_pulse", underflow, 1);
    chk("t4_dout_hold", data_out, 8'h55);
    chk("t4_count0", count, 0);
    tick();
    chk("t4_unf_clear", underflow, 0);
    read_en = 1'b1; write_en = 1'b1; data_in = 8'h33;
    tick();
    write_en = 1'b0;
    chk("t4_unf_rw", underflow, 1);
    chk("t4_count1", count, 1);
    tick();
    read_en = 1'b0;
    chk("t4_dout33", data_out, 8'h33);
    chk("t4_unf_none", underflow, 0);
    chk("t4_count_end", count, 0);

    // 5: reset mid-operation overrides write/read
    for (int i = 0; i < 5; i++) begin
      write_en = 1'b1; data_in = 8'(8'h40 + i);
      tick();
    end
    chk("t5_count5", count, 5);
    reset = 1'b1; write_en = 1'b1; read_en = 1'b1; data_in = 8'hEE;
    tick();
    reset = 1'b0; write_en = 1'b0; read_en = 1'b0;
    chk("t5_count", count, 0);
    chk("t5_empty", empty, 1);
    chk("t5_dout", data_out, 0);
    chk("t5_ae", almost_empty, 1);
    chk("t5_af", almost_full, 0);
    chk("t5_full", full, 0);
    chk("t5_ovf", overflow, 0);
    chk("t5_unf", underflow, 0);
    write_en = 1'b1; data_in = 8'h77;
    tick();
    write_en = 1'b0; read_en = 1'b1;
    tick();
    read_en = 1'b0;
    chk("t5_dout77", data_out, 8'h77);
    chk("t5_count_end", count, 0);
`else
    // 6: first-word-fall-through
    write_en = 1'b1; data_in = 8'h11;
    tick();
    chk("t6_dout11", data_out, 8'h11);
    chk("t6_count1", count, 1);
    data_in = 8'h22;
    tick();
    write_en = 1'b0;
    chk("t6_dout11_hold", data_out, 8'h11);
    chk("t6_count2", count, 2);
    read_en = 1'b1;
    tick();
    chk("t6_dout22", data_out, 8'h22);
    chk("t6_count_pop", count, 1);
    tick();
    read_en = 1'b0;
    chk("t6_empty", empty, 1);
    chk("t6_dout0", data_out, 0);
    chk("t6_unf", underflow, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
